fmc_adc_acq_seq: RTL and testbench

- Acquisition sequencer for the FMC-ADC 100MS core.
- Sequences pre-trigger fill, trigger wait, post-trigger capture and multi-shot repetition for the sample stream.
- Drives sample write-enables, trigger tag strobes and end-of-acquisition events towards the multishot RAM / DDR writer and the interrupt logic.
- Exposes its state to the CSR STA.FSM field.

---
 rtl/fmc_adc_acq_pkg.sv | 20 ++
 rtl/fmc_adc_acq_counter.sv | 27 ++
 rtl/fmc_adc_acq_seq.sv | 142 ++++++++++++++
 tb/tb_fmc_adc_acq_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fmc_adc_acq_pkg.sv
// Shared state encoding and constants for the FMC-ADC acquisition sequencer.
// Encodings are frozen because STA.FSM reports them to software.
package fmc_adc_acq_pkg;

   typedef enum logic [2:0] {
      ACQ_IDLE      = 3'd1,
      ACQ_PRE_TRIG  = 3'd2,
      ACQ_WAIT_TRIG = 3'd3,
      ACQ_POST_TRIG = 3'd4,
      ACQ_DECR_SHOT = 3'd5
   } acq_state_t;

   localparam logic [2:0]  c_ACQ_IDLE        = ACQ_IDLE;
   localparam logic [2:0]  c_ACQ_PRE_TRIG    = ACQ_PRE_TRIG;
   localparam logic [2:0]  c_ACQ_WAIT_TRIG   = ACQ_WAIT_TRIG;
   localparam logic [2:0]  c_ACQ_POST_TRIG   = ACQ_POST_TRIG;
   localparam logic [2:0]  c_ACQ_DECR_SHOT   = ACQ_DECR_SHOT;
   localparam logic [15:0] c_TRIG_MISSED_MAX = 16'hFFFF;

endpackage

// File: rtl/fmc_adc_acq_counter.sv
// Loadable up-counter; tc flags that the next increment lands on term.
module fmc_adc_acq_counter #(
   parameter int unsigned g_width = 32
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   input  logic               ld,
   input  logic [g_width-1:0] ld_val,
   input  logic               inc,
   input  logic [g_width-1:0] term,
   output logic [g_width-1:0] cnt,
   output logic               tc
);

   localparam logic [g_width:0]   c_ONE_W = 1;
   localparam logic [g_width-1:0] c_ONE   = 1;

   // One extra bit so the compare is correct even when term is all ones
   assign tc = ({1'b0, cnt} + c_ONE_W) == {1'b0, term};

   always_ff @(posedge clk_sys) begin
      if (!rst_n)   cnt <= '0;
      else if (ld)  cnt <= ld_val;
      else if (inc) cnt <= cnt + c_ONE;
   end

endmodule

// File: rtl/fmc_adc_acq_seq.sv
// Acquisition sequencer: pre-trigger fill, trigger wait, post capture, multi-shot.
// Define FMC_ADC_ACQ_MISSED_TRIG_EN to build the saturating missed-trigger counter.
module fmc_adc_acq_seq
   import fmc_adc_acq_pkg::*;
#(
   parameter int unsigned g_samples_width = 32,
   parameter int unsigned g_shots_width   = 16
) (
   input  logic                       sys_clk_i,
   input  logic                       sys_rst_n_i,
   input  logic                       start_i,
   input  logic                       stop_i,
   input  logic                       cfg_ok_i,
   input  logic [g_samples_width-1:0] pre_samples_i,
   input  logic [g_samples_width-1:0] post_samples_i,
   input  logic [g_shots_width-1:0]   shots_i,
   input  logic                       sample_valid_i,
   input  logic                       trig_i,
   output logic [2:0]                 fsm_state_o,
   output logic                       samp_wr_o,
   output logic                       trig_tag_o,
   output logic                       shot_end_o,
   output logic                       acq_end_o,
   output logic                       cfg_err_o,
   output logic [g_shots_width-1:0]   shots_left_o,
   output logic [g_samples_width-1:0] samp_cnt_o,
   output logic [15:0]                trig_missed_o
);

   localparam logic [g_shots_width-1:0] c_SHOT_ONE = 1;

   logic [2:0]                 state;
   logic [g_samples_width-1:0] pre_q, post_q, cnt_term;
   logic                       start_ok, in_capture, cnt_ld, cnt_inc, cnt_tc;

   assign start_ok    = start_i && cfg_ok_i && (shots_i != '0) && (post_samples_i != '0);
   assign in_capture  = (state == c_ACQ_PRE_TRIG) || (state == c_ACQ_WAIT_TRIG) ||
                        (state == c_ACQ_POST_TRIG);
   assign cnt_term    = (state == c_ACQ_PRE_TRIG) ? pre_q : post_q;
   assign fsm_state_o = state;

   always_comb begin
      cnt_ld  = 1'b0;
      cnt_inc = 1'b0;
      if (stop_i) cnt_ld = 1'b1;
      else begin
         case (state)
            c_ACQ_IDLE:      cnt_ld  = start_ok;
            c_ACQ_PRE_TRIG:  cnt_inc = sample_valid_i && (pre_q != '0);
            c_ACQ_WAIT_TRIG: cnt_ld  = trig_i;
            c_ACQ_POST_TRIG: cnt_inc = sample_valid_i;
            default:         cnt_ld  = 1'b1;
         endcase
      end
   end

   fmc_adc_acq_counter #(.g_width(g_samples_width)) u_samp_cnt (
      .clk_sys (sys_clk_i),
      .rst_n   (sys_rst_n_i),
      .ld      (cnt_ld),
      .ld_val  ('0),
      .inc     (cnt_inc),
      .term    (cnt_term),
      .cnt     (samp_cnt_o),
      .tc      (cnt_tc)
   );

   always_ff @(posedge sys_clk_i) begin
      samp_wr_o  <= 1'b0;
      trig_tag_o <= 1'b0;
      shot_end_o <= 1'b0;
      acq_end_o  <= 1'b0;
      cfg_err_o  <= 1'b0;
      if (!sys_rst_n_i) begin
         state        <= c_ACQ_IDLE;
         shots_left_o <= '0;
         pre_q        <= '0;
         post_q       <= '0;
      end else if (stop_i) begin
         state        <= c_ACQ_IDLE;
         shots_left_o <= '0;
      end else begin
         samp_wr_o <= sample_valid_i && in_capture;
         case (state)
            c_ACQ_IDLE: begin
               if (start_ok) begin
                  pre_q        <= pre_samples_i;
                  post_q       <= post_samples_i;
                  shots_left_o <= shots_i;
                  state        <= c_ACQ_PRE_TRIG;
               end else if (start_i) begin
                  cfg_err_o <= 1'b1;
               end
            end
            c_ACQ_PRE_TRIG: begin
               if (pre_q == '0 || (sample_valid_i && cnt_tc)) state <= c_ACQ_WAIT_TRIG;
            end
            c_ACQ_WAIT_TRIG: begin
               if (trig_i) begin
                  trig_tag_o <= 1'b1;
                  state      <= c_ACQ_POST_TRIG;
               end
            end
            c_ACQ_POST_TRIG: begin
               if (sample_valid_i && cnt_tc) begin
                  if (shots_left_o == c_SHOT_ONE) begin
                     acq_end_o    <= 1'b1;
                     shots_left_o <= '0;
                     state        <= c_ACQ_IDLE;
                  end else begin
                     state <= c_ACQ_DECR_SHOT;
                  end
               end
            end
            c_ACQ_DECR_SHOT: begin
               shots_left_o <= shots_left_o - c_SHOT_ONE;
               shot_end_o   <= 1'b1;
               state        <= c_ACQ_PRE_TRIG;
            end
            default: state <= c_ACQ_IDLE;
         endcase
      end
   end

`ifdef FMC_ADC_ACQ_MISSED_TRIG_EN
   logic [15:0] missed;
   always_ff @(posedge sys_clk_i) begin
      if (!sys_rst_n_i) missed <= '0;
      else if (!stop_i) begin
         if (state == c_ACQ_IDLE && start_ok) missed <= '0;
         else if (trig_i && missed != c_TRIG_MISSED_MAX &&
                  (state == c_ACQ_PRE_TRIG || state == c_ACQ_POST_TRIG ||
                   state == c_ACQ_DECR_SHOT))
            missed <= missed + 16'd1;
      end
   end
   assign trig_missed_o = missed;
`else
   assign trig_missed_o = '0;
`endif

endmodule

// File: tb/tb_fmc_adc_acq_seq.sv
// Randomized bench: each acquisition is walked shot by shot, predicting outputs
// from the sample/trigger stream the bench itself drives.
module tb_fmc_adc_acq_seq;

`ifdef FMC_ADC_ACQ_MISSED_TRIG_EN
   localparam bit MISS_EN = 1'b1;
`else
   localparam bit MISS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start_i, stop_i, cfg_ok_i, sample_valid_i, trig_i;
   logic [31:0] pre_samples_i, post_samples_i;
   logic [15:0] shots_i;
   logic [2:0]  fsm_state_o;
   logic        samp_wr_o, trig_tag_o, shot_end_o, acq_end_o, cfg_err_o;
   logic [15:0] shots_left_o, trig_missed_o;
   logic [31:0] samp_cnt_o;

   int errors = 0;
   int checks = 0;
   int exp_missed = 0;

   always #5 clk = ~clk;

   fmc_adc_acq_seq dut (
      .sys_clk_i      (clk),
      .sys_rst_n_i    (rst_n),
      .start_i        (start_i),
      .stop_i         (stop_i),
      .cfg_ok_i       (cfg_ok_i),
      .pre_samples_i  (pre_samples_i),
      .post_samples_i (post_samples_i),
      .shots_i        (shots_i),
      .sample_valid_i (sample_valid_i),
      .trig_i         (trig_i),
      .fsm_state_o    (fsm_state_o),
      .samp_wr_o      (samp_wr_o),
      .trig_tag_o     (trig_tag_o),
      .shot_end_o     (shot_end_o),
      .acq_end_o      (acq_end_o),
      .cfg_err_o      (cfg_err_o),
      .shots_left_o   (shots_left_o),
      .samp_cnt_o     (samp_cnt_o),
      .trig_missed_o  (trig_missed_o)
   );

   task automatic chk(input string tag, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int st, input bit wr, input bit tg,
                             input bit se, input bit ae, input bit ce, input int sl,
                             input int cnt);
      chk({tag, ".state"},    fsm_state_o,   st);
      chk({tag, ".samp_wr"},  samp_wr_o,     wr);
      chk({tag, ".trig_tag"}, trig_tag_o,    tg);
      chk({tag, ".shot_end"}, shot_end_o,    se);
      chk({tag, ".acq_end"},  acq_end_o,     ae);
      chk({tag, ".cfg_err"},  cfg_err_o,     ce);
      chk({tag, ".shots"},    shots_left_o,  sl);
      chk({tag, ".cnt"},      samp_cnt_o,    cnt);
      chk({tag, ".missed"},   trig_missed_o, exp_missed);
   endtask

   // One clock: inputs held across the edge, outputs then settled for checking
   task automatic step(input logic sv, input logic tr, input logic st);
      sample_valid_i = sv;
      trig_i         = tr;
      start_i        = st;
      @(posedge clk);
      #1;
      sample_valid_i = 1'b0;
      trig_i         = 1'b0;
      start_i        = 1'b0;
      stop_i         = 1'b0;
   endtask

   // Configuration changes mid-acquisition must not disturb the latched values
   task automatic scramble();
      pre_samples_i  = $urandom;
      post_samples_i = $urandom;
      shots_i        = 16'($urandom);
      cfg_ok_i       = 1'($urandom);
   endtask

   task automatic bump_missed(input logic tr);
      if (MISS_EN && tr && exp_missed < 65535) exp_missed++;
   endtask

   // abort: 0 run to completion, 1 stop in WAIT_TRIG, 2 stop mid-post, 3 reset mid-post
   task automatic run_acq(input int pre, input int post, input int shots,
                          input int wait_cyc, input int abort);
      int   n;
      logic sv, tr;
      pre_samples_i  = pre;
      post_samples_i = post;
      shots_i        = 16'(shots);
      cfg_ok_i       = 1'b1;
      step(1'b0, 1'b0, 1'b1);
      exp_missed = 0;
      expect_out("start", 2, 0, 0, 0, 0, 0, shots, 0);
      for (int s = shots; s >= 1; s--) begin
         if (pre == 0) begin
            sv = 1'($urandom); tr = 1'($urandom);
            scramble(); step(sv, tr, 1'($urandom)); bump_missed(tr);
            expect_out("pre0", 3, sv, 0, 0, 0, 0, s, 0);
         end else begin
            n = 0;
            while (n < pre) begin
               sv = 1'($urandom); tr = ($urandom_range(0, 3) == 0);
               scramble(); step(sv, tr, 1'($urandom)); bump_missed(tr);
               if (sv) n++;
               expect_out("pre", (n == pre) ? 3 : 2, sv, 0, 0, 0, 0, s, n);
            end
         end
         for (int k = 0; k < wait_cyc; k++) begin
            sv = 1'($urandom);
            scramble(); step(sv, 1'b0, 1'($urandom));
            expect_out("wait", 3, sv, 0, 0, 0, 0, s, pre);
         end
         if (abort == 1) begin
            stop_i = 1'b1;
            step(1'b1, 1'b1, 1'b1);
            expect_out("stop_wait", 1, 0, 0, 0, 0, 0, 0, 0);
            return;
         end
         sv = 1'($urandom);
         scramble(); step(sv, 1'b1, 1'($urandom));
         expect_out("trig", 4, sv, 1, 0, 0, 0, s, 0);
         n = 0;
         while (n < post) begin
            if (abort >= 2 && n > 0 && n == post / 2) begin
               if (abort == 2) begin
                  stop_i = 1'b1;
                  step(1'b1, 1'b1, 1'b0);
                  expect_out("stop_post", 1, 0, 0, 0, 0, 0, 0, 0);
               end else begin
                  rst_n = 1'b0;
                  step(1'b1, 1'b1, 1'b0);
                  rst_n = 1'b1;
                  exp_missed = 0;
                  expect_out("rst_post", 1, 0, 0, 0, 0, 0, 0, 0);
               end
               return;
            end
            sv = 1'($urandom); tr = ($urandom_range(0, 3) == 0);
            scramble(); step(sv, tr, 1'($urandom)); bump_missed(tr);
            if (sv) n++;
            if (n < post)    expect_out("post", 4, sv, 0, 0, 0, 0, s, n);
            else if (s == 1) expect_out("acq_end", 1, sv, 0, 0, 1, 0, 0, post);
            else             expect_out("post_end", 5, sv, 0, 0, 0, 0, s, post);
         end
         if (s > 1) begin
            tr = 1'($urandom);
            scramble(); step(1'($urandom), tr, 1'($urandom)); bump_missed(tr);
            expect_out("decr", 2, 0, 0, 1, 0, 0, s - 1, 0);
         end
      end
      cfg_ok_i = 1'b0;
      step(1'b1, 1'b1, 1'b0);
      expect_out("idle_after", 1, 0, 0, 0, 0, 0, 0, post);
   endtask

   task automatic reject(input string tag, input bit ok, input int shots, input int post);
      cfg_ok_i       = ok;
      shots_i        = 16'(shots);
      post_samples_i = post;
      pre_samples_i  = 4;
      step(1'b1, 1'b0, 1'b1);
      expect_out(tag, 1, 0, 0, 0, 0, 1, 0, 0);
      step(1'b1, 1'b0, 1'b0);
      expect_out({tag, "_after"}, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; cfg_ok_i = 1'b0;
      sample_valid_i = 1'b0; trig_i = 1'b0;
      pre_samples_i = '0; post_samples_i = '0; shots_i = '0;
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 1, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      reject("rej_cfg",   1'b0, 2, 8);
      reject("rej_shots", 1'b1, 0, 8);
      reject("rej_post",  1'b1, 2, 0);

      run_acq(0, 1, 1, 25, 0);
      run_acq(16, 128, 3, 50, 0);
      run_acq(4, 10, 2, 3, 1);
      run_acq(4, 10, 2, 3, 2);
      run_acq(3, 8, 2, 2, 3);
      for (int i = 0; i < 15; i++)
         run_acq($urandom_range(0, 20), $urandom_range(1, 40), $urandom_range(1, 4),
                 $urandom_range(0, 10), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
